nes_poll_sequencer: RTL and testbench



---
 rtl/nes_pkg.sv | 21 ++
 rtl/nes_in_sync.sv | 20 ++
 rtl/nes_poll_sequencer.sv | 156 +++++++++++++++
 tb/tb_nes_poll_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// Shared NES pad definitions: button bit positions and the poll sequencer state encoding.
package nes_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_LO    = 3'd2,
    S_HI    = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/nes_in_sync.sv
// Two-flop synchronizer for one asynchronous pad data line.
module nes_in_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], d};

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[1];

endmodule

// File: rtl/nes_poll_sequencer.sv
// Request-driven poll of both NES pads: latch, 7 shift clocks, 8 samples per pad,
// then publish active-high buttons and press-edge masks with a one-cycle valid.
module nes_poll_sequencer
  import nes_pkg::*;
#(
  parameter int TICK_DIV = 600,
  parameter int CNT_W    = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       poll_req,
  input  logic       data1,
  input  logic       data2,
  output logic       latch,
  output logic       c_clk,
  output logic       poll_busy,
  output logic       valid,
  output logic [7:0] btn1,
  output logic [7:0] btn2,
  output logic [7:0] press1,
  output logic [7:0] press2
);

  logic s1, s2;

  nes_in_sync u_sync1 (.clk(clk), .rst(rst), .d(data1), .q(s1));
  nes_in_sync u_sync2 (.clk(clk), .rst(rst), .d(data2), .q(s2));

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic               lat2_q, lat2_d;
  logic [7:0]         sr1_q, sr1_d, sr2_q, sr2_d;
  logic [7:0]         btn1_q, btn1_d, btn2_q, btn2_d;
  logic [7:0]         press1_q, press1_d, press2_q, press2_d;
  logic               valid_q, valid_d;
  logic               latch_q, latch_d;
  logic               c_clk_q, c_clk_d;
  logic               busy_q, busy_d;
  logic               tick_last;

  assign tick_last = (cnt_q == CNT_W'(TICK_DIV - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    bit_d    = bit_q;
    lat2_d   = lat2_q;
    sr1_d    = sr1_q;
    sr2_d    = sr2_q;
    btn1_d   = btn1_q;
    btn2_d   = btn2_q;
    press1_d = press1_q;
    press2_d = press2_q;
    valid_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (poll_req) begin
          state_d = S_LATCH;
          lat2_d  = 1'b0;
        end
      end
      // Latch spans two ticks; lat2 marks the second one.
      S_LATCH: begin
        if (tick_last) begin
          cnt_d = '0;
          if (lat2_q) begin
            state_d = S_LO;
            bit_d   = 3'd0;
          end else begin
            lat2_d = 1'b1;
          end
        end
      end
      S_LO: begin
        if (tick_last) begin
          cnt_d        = '0;
          sr1_d[bit_q] = s1;
          sr2_d[bit_q] = s2;
          state_d      = (bit_q == 3'd7) ? S_DONE : S_HI;
        end
      end
      S_HI: begin
        if (tick_last) begin
          cnt_d   = '0;
          bit_d   = bit_q + 3'd1;
          state_d = S_LO;
        end
      end
      S_DONE: begin
        cnt_d    = '0;
        state_d  = S_IDLE;
        btn1_d   = ~sr1_q;
        btn2_d   = ~sr2_q;
        press1_d = ~sr1_q & ~btn1_q;
        press2_d = ~sr2_q & ~btn2_q;
        valid_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Pin strobes follow the next state so they are clean flop outputs.
    latch_d = (state_d == S_LATCH);
    c_clk_d = (state_d == S_HI);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      lat2_q   <= 1'b0;
      sr1_q    <= '0;
      sr2_q    <= '0;
      btn1_q   <= '0;
      btn2_q   <= '0;
      press1_q <= '0;
      press2_q <= '0;
      valid_q  <= 1'b0;
      latch_q  <= 1'b0;
      c_clk_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      lat2_q   <= lat2_d;
      sr1_q    <= sr1_d;
      sr2_q    <= sr2_d;
      btn1_q   <= btn1_d;
      btn2_q   <= btn2_d;
      press1_q <= press1_d;
      press2_q <= press2_d;
      valid_q  <= valid_d;
      latch_q  <= latch_d;
      c_clk_q  <= c_clk_d;
      busy_q   <= busy_d;
    end
  end

  assign latch     = latch_q;
  assign c_clk     = c_clk_q;
  assign poll_busy = busy_q;
  assign valid     = valid_q;
  assign btn1      = btn1_q;
  assign btn2      = btn2_q;
  assign press1    = press1_q;
  assign press2    = press2_q;

endmodule

// File: tb/tb_nes_poll_sequencer.sv
// Directed bench for nes_poll_sequencer at TICK_DIV=4 with a behavioural NES pad model.
module tb_nes_poll_sequencer;

  logic       clk = 1'b0;
  logic       rst, poll_req, data1, data2;
  logic       latch, c_clk, poll_busy, valid;
  logic [7:0] btn1, btn2, press1, press2;

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  logic [7:0] pad1 = 8'h00, pad2 = 8'h00;
  logic       disc = 1'b0;
  int         idx = 0;
  logic       prev_cclk = 1'b0;

  always #5 clk = ~clk;

  nes_poll_sequencer #(.TICK_DIV(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .poll_req(poll_req), .data1(data1), .data2(data2),
    .latch(latch), .c_clk(c_clk), .poll_busy(poll_busy), .valid(valid),
    .btn1(btn1), .btn2(btn2), .press1(press1), .press2(press2)
  );

  // Pad model: latch reloads the button snapshot, each rising c_clk advances one bit.
  always @(posedge clk) begin
    if (latch) idx <= 0;
    else if (c_clk && !prev_cclk && idx < 7) idx <= idx + 1;
    prev_cclk <= c_clk;
  end

  always_comb begin
    data1 = disc ? 1'b1 : ~pad1[idx[2:0]];
    data2 = disc ? 1'b1 : ~pad2[idx[2:0]];
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept a request, then wait (bounded) for valid; returns the cycle it appeared in.
  task automatic do_poll(output int vcyc);
    poll_req = 1'b1;
    step();
    cyc = 1;
    poll_req = 1'b0;
    vcyc = -1;
    for (int i = 0; i < 100; i++) begin
      if (valid) begin
        vcyc = cyc;
        break;
      end
      step();
    end
  endtask

  int vc;
  int act, lat_rise_n, cclk_pulses, bad_w, overlap, lat_len, cclk_len, vcount;
  int lat_rise [3];
  int vcycs [3];

  initial begin
    rst = 1'b1; poll_req = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset_latch", {31'd0, latch}, 0);
    check("reset_cclk", {31'd0, c_clk}, 0);
    check("reset_busy", {31'd0, poll_busy}, 0);
    check("reset_valid", {31'd0, valid}, 0);
    check("reset_btn", {16'd0, btn1, btn2}, 0);
    check("reset_press", {16'd0, press1, press2}, 0);
    act = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (latch || c_clk || poll_busy || valid) act++;
    end
    check("idle_quiet", act, 0);

    // Poll 1: A+Right on pad 1
    pad1 = 8'h81; pad2 = 8'h00;
    do_poll(vc);
    check("p1_valid_cycle", vc, 70);
    check("p1_btn1", btn1, 8'h81);
    check("p1_btn2", btn2, 8'h00);
    check("p1_press1", press1, 8'h81);
    check("p1_press2", press2, 8'h00);
    step();
    check("p1_valid_pulse", {31'd0, valid}, 0);
    check("p1_btn1_hold", btn1, 8'h81);

    do_poll(vc);
    check("p2_valid_cycle", vc, 70);
    check("p2_btn1", btn1, 8'h81);
    check("p2_press1", press1, 8'h00);

    pad1 = 8'h88;
    do_poll(vc);
    check("p3_btn1", btn1, 8'h88);
    check("p3_press1", press1, 8'h08);
    step();

    // Back-to-back polls with poll_req held
    poll_req = 1'b1;
    step();
    cyc = 1;
    lat_rise_n = 0; cclk_pulses = 0; bad_w = 0; overlap = 0;
    lat_len = 0; cclk_len = 0; vcount = 0;
    for (int c = 1; c <= 210; c++) begin
      if (latch && lat_len == 0) begin
        if (lat_rise_n < 3) lat_rise[lat_rise_n] = c;
        lat_rise_n++;
      end
      if (latch) lat_len++;
      else begin
        if (lat_len != 0 && lat_len != 8) bad_w++;
        lat_len = 0;
      end
      if (c_clk) cclk_len++;
      else begin
        if (cclk_len != 0) begin
          cclk_pulses++;
          if (cclk_len != 4) bad_w++;
        end
        cclk_len = 0;
      end
      if (latch && c_clk) overlap++;
      if (valid) begin
        if (vcount < 3) vcycs[vcount] = c;
        vcount++;
      end
      if (c == 200) poll_req = 1'b0;
      if (c != 210) step();
    end
    check("b2b_latch_rises", lat_rise_n, 3);
    check("b2b_latch_rise0", lat_rise[0], 1);
    check("b2b_latch_rise1", lat_rise[1], 71);
    check("b2b_latch_rise2", lat_rise[2], 141);
    check("b2b_cclk_pulses", cclk_pulses, 21);
    check("b2b_widths", bad_w, 0);
    check("b2b_overlap", overlap, 0);
    check("b2b_valids", vcount, 3);
    check("b2b_valid_last", vcycs[2], 210);
    check("b2b_press1", press1, 8'h00);
    repeat (5) step();

    // Reset during HI(3), which spans cycles 37..40
    poll_req = 1'b1;
    step();
    cyc = 1;
    poll_req = 1'b0;
    while (cyc < 38) step();
    check("mid_in_hi", {31'd0, c_clk}, 1);
    rst = 1'b1;
    step();
    check("mid_latch", {31'd0, latch}, 0);
    check("mid_cclk", {31'd0, c_clk}, 0);
    check("mid_busy", {31'd0, poll_busy}, 0);
    check("mid_valid", {31'd0, valid}, 0);
    check("mid_btn", {16'd0, btn1, btn2}, 0);
    rst = 1'b0;
    vcount = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (valid || poll_busy) vcount++;
    end
    check("mid_no_valid", vcount, 0);
    do_poll(vc);
    check("post_rst_cycle", vc, 70);
    check("post_rst_btn1", btn1, 8'h88);
    check("post_rst_press1", press1, 8'h88);

    pad2 = 8'h5A;
    do_poll(vc);
    check("p2pad_btn2", btn2, 8'h5A);
    check("p2pad_press2", press2, 8'h5A);
    check("p2pad_press1", press1, 8'h00);

    // Disconnected pads
    disc = 1'b1;
    do_poll(vc);
    check("disc_valid_cycle", vc, 70);
    check("disc_btn", {16'd0, btn1, btn2}, 0);
    check("disc_press", {16'd0, press1, press2}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
